// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter
// Two-master classic Wishbone arbiter and sequencer in front of a single-port,
// byte-enable RAM with a 1-cycle registered read latency.
// Master 0 is instruction fetch and master 1 is data load/store.
// Each transaction takes IDLE -> ACCESS -> ACK, which is at least 3 cycles.
// The RAM strobes are gated with reset, so a reset edge can never commit a write.
module wb_ram_arbiter #(
  parameter int depth      = 256,
  parameter int aw         = $clog2(depth),
  parameter bit fixed_prio = 1'b0
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  // master 0 (instruction fetch)
  input  logic [aw-1:0] i_m0_adr,
  input  logic [31:0]   i_m0_dat,
  input  logic [3:0]    i_m0_sel,
  input  logic          i_m0_we,
  input  logic          i_m0_cyc,
  output logic [31:0]   o_m0_rdt,
  output logic          o_m0_ack,
  // master 1 (data load/store)
  input  logic [aw-1:0] i_m1_adr,
  input  logic [31:0]   i_m1_dat,
  input  logic [3:0]    i_m1_sel,
  input  logic          i_m1_we,
  input  logic          i_m1_cyc,
  output logic [31:0]   o_m1_rdt,
  output logic          o_m1_ack,
  // RAM port
  output logic [aw-1:0] o_ram_adr,
  output logic [31:0]   o_ram_dat,
  output logic [3:0]    o_ram_sel,
  output logic          o_ram_we,
  output logic          o_ram_cyc,
  input  logic [31:0]   i_ram_rdt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   grant;
  logic   next_grant;
  logic   last_grant;
  logic   next_last_grant;
  logic   granted_cyc;
  logic   granted_we;
  logic   tie_winner;

  // Route the granted master's request onto the RAM address/data/sel lines.
  // The lines keep following the granted master outside ACCESS; the RAM
  // ignores them there because o_ram_cyc is low.
  always_comb begin
    granted_cyc = i_m0_cyc;
    granted_we  = i_m0_we;
    o_ram_adr   = i_m0_adr;
    o_ram_dat   = i_m0_dat;
    o_ram_sel   = i_m0_sel;
    if (grant) begin
      granted_cyc = i_m1_cyc;
      granted_we  = i_m1_we;
      o_ram_adr   = i_m1_adr;
      o_ram_dat   = i_m1_dat;
      o_ram_sel   = i_m1_sel;
    end else begin
      granted_cyc = i_m0_cyc;
      granted_we  = i_m0_we;
      o_ram_adr   = i_m0_adr;
      o_ram_dat   = i_m0_dat;
      o_ram_sel   = i_m0_sel;
    end
  end

  // Pick the winner when both masters request in the same IDLE cycle.
  // Round-robin hands the port to whoever did not finish last.
  always_comb begin
    tie_winner = 1'b0;
    if (fixed_prio) begin
      tie_winner = 1'b0;
    end else begin
      tie_winner = ~last_grant;
    end
  end

  // FSM and grant registers. After reset, last_grant is 1 so that master 0
  // wins the first tie.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= next_state;
      grant      <= next_grant;
      last_grant <= next_last_grant;
    end
  end

  // Compute the next state and the grant/last_grant updates.
  // A cyc that is still high in IDLE starts a fresh transaction.
  always_comb begin
    next_state      = state;
    next_grant      = grant;
    next_last_grant = last_grant;
    case (state)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          next_grant = tie_winner;
          next_state = ACCESS;
        end else if (i_m0_cyc) begin
          next_grant = 1'b0;
          next_state = ACCESS;
        end else if (i_m1_cyc) begin
          next_grant = 1'b1;
          next_state = ACCESS;
        end else begin
          next_state = IDLE;
        end
      end
      ACCESS: begin
        // A granted master that dropped cyc has aborted: no ack is issued.
        if (granted_cyc) begin
          next_state = ACK;
        end else begin
          next_state = IDLE;
        end
      end
      ACK: begin
        next_last_grant = grant;
        next_state      = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Decode the RAM strobes and the per-master ack/rdt from the state.
  // All of them are forced low while reset is asserted.
  always_comb begin
    o_ram_cyc = 1'b0;
    o_ram_we  = 1'b0;
    o_m0_ack  = 1'b0;
    o_m1_ack  = 1'b0;
    o_m0_rdt  = 32'h0000_0000;
    o_m1_rdt  = 32'h0000_0000;
    if (!i_wb_rst) begin
      case (state)
        ACCESS: begin
          o_ram_cyc = granted_cyc;
          o_ram_we  = granted_cyc & granted_we;
        end
        ACK: begin
          // For a write, i_ram_rdt is the word as it was before the write.
          // The master must ignore it.
          if (grant) begin
            o_m1_ack = 1'b1;
            o_m1_rdt = i_ram_rdt;
          end else begin
            o_m0_ack = 1'b1;
            o_m0_rdt = i_ram_rdt;
          end
        end
        default: begin
          o_ram_cyc = 1'b0;
          o_ram_we  = 1'b0;
        end
      endcase
    end else begin
      o_ram_cyc = 1'b0;
      o_ram_we  = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb_wb_ram_arbiter
// Drives two arbiters from one pair of masters. One arbiter is round-robin and
// has a byte-enable RAM model behind it; the other uses fixed priority.
// Expected read data is queued per master when a request is driven, and it is
// popped and compared when that master's ack appears.
module tb_wb_ram_arbiter;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_init;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [31:0]   m0_dat, m1_dat;
  logic [3:0]    m0_sel, m1_sel;
  logic          m0_we, m1_we, m0_cyc, m1_cyc;

  logic [31:0]   rr_m0_rdt, rr_m1_rdt, ram_rdt;
  logic          rr_m0_ack, rr_m1_ack;
  logic [AW-1:0] rr_ram_adr;
  logic [31:0]   rr_ram_dat;
  logic [3:0]    rr_ram_sel;
  logic          rr_ram_we, rr_ram_cyc;

  logic [31:0]   fp_m0_rdt, fp_m1_rdt;
  logic          fp_m0_ack, fp_m1_ack;
  logic [AW-1:0] fp_ram_adr;
  logic [31:0]   fp_ram_dat;
  logic [3:0]    fp_ram_sel;
  logic          fp_ram_we, fp_ram_cyc;
  logic [31:0]   fp_ram_rdt;

  logic [31:0]   mem [0:63];
  logic [31:0]   ref_mem [0:63];
  logic [31:0]   sb_q0 [$];
  logic [31:0]   sb_q1 [$];
  int            pass_cnt = 0;
  int            total_cnt = 0;

  typedef struct {
    logic          m;
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic [31:0]   exp_rdt;
  } vec_t;
  vec_t vecs [10];

  always #5 clk = ~clk;

  wb_ram_arbiter #(.depth(256), .fixed_prio(1'b0)) dut_rr (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we),
    .i_m0_cyc(m0_cyc), .o_m0_rdt(rr_m0_rdt), .o_m0_ack(rr_m0_ack),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
    .i_m1_cyc(m1_cyc), .o_m1_rdt(rr_m1_rdt), .o_m1_ack(rr_m1_ack),
    .o_ram_adr(rr_ram_adr), .o_ram_dat(rr_ram_dat), .o_ram_sel(rr_ram_sel),
    .o_ram_we(rr_ram_we), .o_ram_cyc(rr_ram_cyc), .i_ram_rdt(ram_rdt)
  );

  wb_ram_arbiter #(.depth(256), .fixed_prio(1'b1)) dut_fp (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we),
    .i_m0_cyc(m0_cyc), .o_m0_rdt(fp_m0_rdt), .o_m0_ack(fp_m0_ack),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
    .i_m1_cyc(m1_cyc), .o_m1_rdt(fp_m1_rdt), .o_m1_ack(fp_m1_ack),
    .o_ram_adr(fp_ram_adr), .o_ram_dat(fp_ram_dat), .o_ram_sel(fp_ram_sel),
    .o_ram_we(fp_ram_we), .o_ram_cyc(fp_ram_cyc), .i_ram_rdt(fp_ram_rdt)
  );

  assign fp_ram_rdt = 32'h0;

  // Byte-enable RAM model: registered read-before-write with 1-cycle latency.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      ram_rdt <= 32'h0;
    end else if (rr_ram_cyc) begin
      ram_rdt <= mem[rr_ram_adr[7:2]];
      if (rr_ram_we) begin
        for (int b = 0; b < 4; b++)
          if (rr_ram_sel[b]) mem[rr_ram_adr[7:2]][8*b +: 8] <= rr_ram_dat[8*b +: 8];
      end
    end
  end

  // Stop a run that would otherwise never end.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: event occurred that must not", name);
  endtask

  // Match any ack against the scoreboard, and require rdt=0 while there is no ack.
  task automatic scoreboard_sample();
    logic [31:0] e;
    if (rr_m0_ack) begin
      if (sb_q0.size() == 0) fail_now("m0 unexpected ack");
      else begin
        e = sb_q0.pop_front();
        check("m0 rdt", 64'(rr_m0_rdt), 64'(e));
      end
    end else begin
      check("m0 rdt idle", 64'(rr_m0_rdt), 64'h0);
    end
    if (rr_m1_ack) begin
      if (sb_q1.size() == 0) fail_now("m1 unexpected ack");
      else begin
        e = sb_q1.pop_front();
        check("m1 rdt", 64'(rr_m1_rdt), 64'(e));
      end
    end else begin
      check("m1 rdt idle", 64'(rr_m1_rdt), 64'h0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    scoreboard_sample();
  endtask

  task automatic drive(input logic m, input logic we, input logic [AW-1:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    if (m) begin
      m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = sel; m1_cyc = 1'b1;
    end else begin
      m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = sel; m0_cyc = 1'b1;
    end
  endtask

  // One single-master transaction: check the ACCESS-cycle RAM strobes and
  // the ack latency, then update the reference memory.
  task automatic do_txn(input logic m, input logic we, input logic [AW-1:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic [31:0] exp_rdt);
    bit   got;
    logic mack;
    got = 1'b0;
    drive(m, we, adr, dat, sel);
    if (m) sb_q1.push_back(exp_rdt);
    else sb_q0.push_back(exp_rdt);
    for (int k = 1; k <= 10 && !got; k++) begin
      step();
      if (k == 1)
        check("access strobes", 64'({rr_ram_cyc, rr_ram_we, rr_ram_adr, rr_ram_sel, rr_ram_dat}),
              64'({1'b1, we, adr, sel, dat}));
      mack = m ? rr_m1_ack : rr_m0_ack;
      if (mack) begin
        got = 1'b1;
        check("ack latency", 64'(k), 64'd2);
        if (m) m1_cyc = 1'b0;
        else m0_cyc = 1'b0;
      end
    end
    if (!got) begin
      fail_now("ack timeout");
      m0_cyc = 1'b0; m1_cyc = 1'b0;
      sb_q0.delete(); sb_q1.delete();
    end
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[adr[7:2]][8*b +: 8] = dat[8*b +: 8];
    end
    step();
  endtask

  initial begin
    int bad;
    logic [3:0] exp_v;
    vecs[0] = '{1'b1, 1'b1, 8'd8,   32'hDEADBEEF, 4'b0101, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 8'd8,   32'h00000000, 4'b1111, 32'h00AD00EF};
    vecs[2] = '{1'b0, 1'b1, 8'd12,  32'hCAFEF00D, 4'b1111, 32'h00000000};
    vecs[3] = '{1'b0, 1'b0, 8'd12,  32'h00000000, 4'b1111, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b1, 8'd12,  32'h11223344, 4'b1000, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 1'b0, 8'd14,  32'h00000000, 4'b1111, 32'h11FEF00D};
    vecs[6] = '{1'b1, 1'b1, 8'd8,   32'hFFFFFFFF, 4'b0000, 32'h00AD00EF};
    vecs[7] = '{1'b1, 1'b0, 8'd8,   32'h00000000, 4'b1111, 32'h00AD00EF};
    vecs[8] = '{1'b0, 1'b1, 8'd252, 32'hA5A5A5A5, 4'b0011, 32'h00000000};
    vecs[9] = '{1'b1, 1'b0, 8'd252, 32'h00000000, 4'b1111, 32'h0000A5A5};
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

    // Reset with both masters requesting.
    rst = 1'b1; mem_init = 1'b1;
    drive(1'b0, 1'b0, 8'h10, 32'h0, 4'b1111);
    drive(1'b1, 1'b0, 8'h20, 32'h0, 4'b1111);
    sb_q0.push_back(32'h0);
    sb_q1.push_back(32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("reset outputs", 64'({rr_m0_ack, rr_m1_ack, rr_ram_cyc, rr_ram_we,
                                  fp_m0_ack, fp_m1_ack, fp_ram_cyc, fp_ram_we}), 64'h0);
    end
    rst = 1'b0; mem_init = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) check("first grant adr", 64'({rr_ram_adr, fp_ram_adr, fp_ram_sel, fp_ram_dat}),
                        64'({8'h10, 8'h10, 4'b1111, 32'h0}));
      exp_v = {(k == 2), (k == 5), 2'b00};
      check("post-reset acks", 64'({rr_m0_ack, rr_m1_ack, 2'b00}), 64'(exp_v));
      if (rr_m0_ack) m0_cyc = 1'b0;
      if (rr_m1_ack) m1_cyc = 1'b0;
    end
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    step();

    // Table of single transactions.
    for (int i = 0; i < 10; i++)
      do_txn(vecs[i].m, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].exp_rdt);

    // Both masters hold cyc: round-robin alternates, fixed priority starves m1.
    drive(1'b0, 1'b0, 8'd12, 32'h0, 4'b1111);
    drive(1'b1, 1'b0, 8'd8,  32'h0, 4'b1111);
    sb_q0.push_back(32'h11FEF00D); sb_q0.push_back(32'h11FEF00D);
    sb_q1.push_back(32'h00AD00EF); sb_q1.push_back(32'h00AD00EF);
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_v = {(k == 2 || k == 8), (k == 5 || k == 11), ((k % 3) == 2), 1'b0};
      check("tie ack pattern", 64'({rr_m0_ack, rr_m1_ack, fp_m0_ack, fp_m1_ack}), 64'(exp_v));
      check("fp rdt", 64'(fp_m0_rdt | fp_m1_rdt), 64'h0);
      if (k == 11) begin m0_cyc = 1'b0; m1_cyc = 1'b0; end
    end
    step();
    check("queues drained", 64'(sb_q0.size() + sb_q1.size()), 64'd0);

    // Abort: m0 drops cyc in the ACCESS cycle of a write.
    drive(1'b0, 1'b1, 8'd16, 32'h55AA55AA, 4'b1111);
    step();
    check("abort access", 64'({rr_ram_cyc, rr_ram_we}), 64'({1'b1, 1'b1}));
    m0_cyc = 1'b0;
    #1;
    check("abort strobes", 64'({rr_ram_cyc, rr_ram_we}), 64'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort no ack", 64'({rr_m0_ack, rr_m1_ack, rr_ram_cyc}), 64'h0);
    end
    check("abort mem", 64'(mem[4]), 64'(ref_mem[4]));
    do_txn(1'b0, 1'b0, 8'd16, 32'h0, 4'b1111, 32'h0);

    // Reset in the ACCESS cycle of an m1 write.
    drive(1'b1, 1'b1, 8'd20, 32'h12345678, 4'b1111);
    step();
    check("rst access", 64'({rr_ram_cyc, rr_ram_we}), 64'({1'b1, 1'b1}));
    rst = 1'b1;
    #1;
    check("rst gates strobes", 64'({rr_ram_cyc, rr_ram_we}), 64'h0);
    step();
    check("rst no ack", 64'({rr_m0_ack, rr_m1_ack}), 64'h0);
    rst = 1'b0; m1_cyc = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("post-rst no ack", 64'({rr_m0_ack, rr_m1_ack, rr_ram_cyc}), 64'h0);
    end
    check("rst mem", 64'(mem[5]), 64'(ref_mem[5]));
    do_txn(1'b1, 1'b1, 8'd20, 32'h12345678, 4'b1111, 32'h0);
    do_txn(1'b1, 1'b0, 8'd20, 32'h0, 4'b1111, 32'h12345678);

    // The whole RAM image must match the reference.
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem image", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
